mul_booth_pipe: RTL and testbench
=================================

MUL_BOOTH_PIPE -- requirements
Module: mul_booth_pipe

Parameters
REQ-001 The block SHALL have a parameter W, default 16: the operand width, even, legal range 8..32.
REQ-002 The block SHALL have a parameter TW, default 4: the sideband tag width, legal range 1..16.

Interface
REQ-003 The block SHALL have port clk, input, 1 bit: the only clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous reset, active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operand pair is present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand pair this cycle.
REQ-007 The block SHALL have port in_a, input, W bits: multiplicand.
REQ-008 The block SHALL have port in_b, input, W bits: multiplier.
REQ-009 The block SHALL have port in_signed, input, 1 bit: 1 means both operands are two's complement; 0 means both are unsigned.
REQ-010 The block SHALL have port in_tag, input, TW bits: sideband data, passed through unchanged.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the result is present.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the downstream stage accepts the result.
REQ-013 The block SHALL have port out_product, output, 2W bits: the product a*b, two's complement in signed mode, unsigned in unsigned mode.
REQ-014 The block SHALL have port out_tag, output, TW bits: the tag that entered with the operand pair.

Function
REQ-015 Transfer SHALL occur on a port when valid and ready are both 1 at a rising edge; in_ready SHALL NOT depend combinationally on in_valid.
REQ-016 Operand extension SHALL be to W+2 bits (even count for radix-4): sign extension when in_signed=1, zero extension when in_signed=0.
REQ-017 Stage 1 SHALL register (W+2)/2 radix-4 Booth partial products, sign-extended to 2W bits, plus their negate-carry bits, together with valid and tag.
REQ-018 Stage 2 SHALL reduce all partial products and negate carries with a 3:2 carry-save tree to one sum vector and one carry vector, and register both with valid and tag.
REQ-019 Stage 3 SHALL add sum and carry with a 2W-bit carry-lookahead adder, discard the carry-out, and register the result into out_product, out_tag and out_valid.
REQ-020 The result SHALL be exact modulo 2^(2W) in both modes; no truncation, rounding or saturation.
REQ-021 Latency SHALL be 3 cycles: a pair accepted at edge N appears with out_valid=1 after edge N+3 when out_ready stays 1.
REQ-022 Throughput SHALL be one pair per cycle while out_ready=1.
REQ-023 Stall: a global enable en = !(out_valid && !out_ready) SHALL gate all stage registers; in_ready SHALL equal en.
REQ-024 When en=0, every stage register and every output SHALL hold its value; no pair SHALL be lost or duplicated.
REQ-025 Bubbles (stage valid=0) SHALL advance like data; they SHALL NOT be squeezed out while en=1.
REQ-026 Ordering SHALL be strict FIFO; each out_tag SHALL match the tag of the pair that produced it.
REQ-027 The mode SHALL be captured per pair at acceptance; mixed-mode back-to-back pairs SHALL each compute in their own mode.
REQ-028 out_product and out_tag are don't-care when out_valid=0, but SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-029 While rst=1, all stage valid bits and out_valid SHALL be 0 at the next edge; out_product and out_tag SHALL be 0.
REQ-030 While rst=1, in_ready SHALL be 1, but no pair presented SHALL be accepted.
REQ-031 Reset mid-operation SHALL discard all in-flight pairs; no stale result SHALL appear after reset is released.

Verification
REQ-032 The bench SHALL check signed W=16: a=0x8000, b=0x8000 -> out_product=0x40000000; a=0xFFFF, b=0xFFFF -> 0x00000001; a=0x7FFF, b=0x8000 -> 0xC0008000.
REQ-033 The bench SHALL check unsigned W=16: a=0xFFFF, b=0xFFFF -> 0xFFFE0001; a=0x8000, b=0x0002 -> 0x00010000; the same pairs in consecutive cycles with alternating in_signed -> each result matches its own mode.
REQ-034 The bench SHALL check streaming: 100 back-to-back random pairs with out_ready=1 -> first result 3 cycles after the first accept, one result per cycle, tags in order.
REQ-035 The bench SHALL check backpressure: out_ready held at 0 for 5 cycles with the pipe full -> in_ready=0, the output stable, no loss; after release, results continue in order with no gaps.
REQ-036 The bench SHALL check reset mid-stream: rst=1 for 1 cycle with 3 pairs in flight -> out_valid=0 the next cycle, and only post-reset pairs emerge.
REQ-037 The bench SHALL check parameter sweep: W=8, 12, 32 with random signed and unsigned operands against a reference model -> bit-exact, including the corner values 0, 1, min and max.

Source files
------------

// File: rtl/mul_booth_pipe.sv
// Pipelined radix-4 Booth multiplier, signed or unsigned per operand pair.
// Stages: input capture, Booth partial products, 3:2 CSA reduction, CLA final add.
module mul_booth_pipe #(
  parameter int W  = 16,
  parameter int TW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_a,
  input  logic [W-1:0]    in_b,
  input  logic            in_signed,
  input  logic [TW-1:0]   in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  out_product,
  output logic [TW-1:0]   out_tag
);
  localparam int PW  = 2 * W;
  localparam int EW  = W + 2;
  localparam int NPP = EW / 2;
  localparam int NR  = NPP + 1;

  logic                 en;
  logic                 vld_p0, vld_p1, vld_p2;
  logic [W-1:0]         a_p0, b_p0;
  logic                 sgn_p0;
  logic [TW-1:0]        tag_p0, tag_p1, tag_p2;
  logic [PW-1:0]        pp_p1 [NPP];
  logic [PW-1:0]        negc_p1;
  logic [PW-1:0]        sum_p2, carry_p2;

  logic signed [EW-1:0] ext_a, ext_b;
  logic [EW:0]          b_win;
  logic [PW-1:0]        pp_c [NPP];
  logic [PW-1:0]        negc_c;
  logic [PW-1:0]        lvl [NR];
  logic [PW-1:0]        nxt [NR];
  int                   cnt;
  logic [PW-1:0]        sum_c, carry_c;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  function automatic logic booth_neg(input logic [2:0] sel);
    return sel[2] & ~(sel[1] & sel[0]);
  endfunction

  // Row = digit * a * 4^idx in ones'-complement form; the +1 lives in the negate-carry row.
  function automatic logic [PW-1:0] booth_row(input logic signed [EW-1:0] a,
                                              input logic [2:0] sel, input int idx);
    logic [EW:0]   mag;
    logic [PW-1:0] row;
    case (sel)
      3'b001, 3'b010, 3'b101, 3'b110: mag = {a[EW-1], a};
      3'b011, 3'b100:                 mag = {a, 1'b0};
      default:                        mag = '0;
    endcase
    if (booth_neg(sel)) mag = ~mag;
    row = {{(PW-EW-1){mag[EW]}}, mag};
    return row << (2 * idx);
  endfunction

  function automatic logic [PW-1:0] csa_sum(input logic [PW-1:0] x, y, z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [PW-1:0] csa_carry(input logic [PW-1:0] x, y, z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  // Kogge-Stone prefix carry lookahead; carry-out of the top bit is dropped.
  function automatic logic [PW-1:0] cla_add(input logic [PW-1:0] x, y);
    logic [PW-1:0] p, gg, pp;
    p  = x ^ y;
    gg = x & y;
    pp = p;
    for (int d = 1; d < PW; d = d * 2) begin
      for (int i = PW - 1; i >= d; i--) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    return p ^ (gg << 1);
  endfunction

  // ---- stage 0 -> 1: Booth encoding of the captured operands ----
  assign ext_a = {{2{sgn_p0 & a_p0[W-1]}}, a_p0};
  assign ext_b = {{2{sgn_p0 & b_p0[W-1]}}, b_p0};
  assign b_win = {ext_b, 1'b0};

  always_comb begin
    negc_c = '0;
    for (int i = 0; i < NPP; i++) begin
      pp_c[i]      = booth_row(ext_a, b_win[2*i +: 3], i);
      negc_c[2*i]  = booth_neg(b_win[2*i +: 3]);
    end
  end

  // ---- stage 1 -> 2: layered 3:2 reduction down to sum and carry ----
  always_comb begin
    for (int i = 0; i < NPP; i++) lvl[i] = pp_p1[i];
    lvl[NPP] = negc_p1;
    cnt = NR;
    for (int l = 0; l < NR; l++) begin
      for (int i = 0; i < NR; i++) nxt[i] = '0;
      for (int g = 0; g < NR / 3; g++) begin
        if (g < cnt / 3) begin
          nxt[2*g]   = csa_sum(lvl[3*g], lvl[3*g+1], lvl[3*g+2]);
          nxt[2*g+1] = csa_carry(lvl[3*g], lvl[3*g+1], lvl[3*g+2]);
        end
      end
      for (int r = 0; r < NR; r++) begin
        if (r >= 3 * (cnt / 3) && r < cnt) nxt[2 * (cnt / 3) + r - 3 * (cnt / 3)] = lvl[r];
      end
      if (cnt > 2) begin
        lvl = nxt;
        cnt = 2 * (cnt / 3) + cnt % 3;
      end
    end
    sum_c   = lvl[0];
    carry_c = lvl[1];
  end

  // ---- control and output registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      out_valid   <= 1'b0;
      out_product <= '0;
      out_tag     <= '0;
    end else if (en) begin
      vld_p0      <= in_valid;
      vld_p1      <= vld_p0;
      vld_p2      <= vld_p1;
      out_valid   <= vld_p2;
      out_product <= cla_add(sum_p2, carry_p2);
      out_tag     <= tag_p2;
    end
  end

  // ---- datapath registers, advanced only by the global enable ----
  always_ff @(posedge clk) begin
    if (en) begin
      a_p0     <= in_a;
      b_p0     <= in_b;
      sgn_p0   <= in_signed;
      tag_p0   <= in_tag;
      pp_p1    <= pp_c;
      negc_p1  <= negc_c;
      tag_p1   <= tag_p0;
      sum_p2   <= sum_c;
      carry_p2 <= carry_c;
      tag_p2   <= tag_p1;
    end
  end

endmodule

// File: tb/tb_mul_booth_pipe.sv
// Bench for mul_booth_pipe: corner products, streaming, backpressure, reset, width sweep.
module tb_mul_booth_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, in_signed = 1'b0, out_valid, out_ready = 1'b1;
  logic [15:0] in_a = '0, in_b = '0;
  logic [3:0]  in_tag = '0, out_tag;
  logic [31:0] out_product;

  logic        s8_v = 1'b0,  s8_rdy,  s8_s = 1'b0,  s8_ov;
  logic [7:0]  s8_a = '0,  s8_b = '0;
  logic [0:0]  s8_t = '0,  s8_ot;
  logic [15:0] s8_p;
  logic        s12_v = 1'b0, s12_rdy, s12_s = 1'b0, s12_ov;
  logic [11:0] s12_a = '0, s12_b = '0;
  logic [7:0]  s12_t = '0, s12_ot;
  logic [23:0] s12_p;
  logic        s32_v = 1'b0, s32_rdy, s32_s = 1'b0, s32_ov;
  logic [31:0] s32_a = '0, s32_b = '0;
  logic [15:0] s32_t = '0, s32_ot;
  logic [63:0] s32_p;

  typedef struct packed { logic [31:0] p; logic [3:0] t; } exp_t;
  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mul_booth_pipe #(.W(16), .TW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_tag(out_tag));
  mul_booth_pipe #(.W(8), .TW(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(s8_v), .in_ready(s8_rdy), .in_a(s8_a), .in_b(s8_b),
    .in_signed(s8_s), .in_tag(s8_t), .out_valid(s8_ov), .out_ready(1'b1),
    .out_product(s8_p), .out_tag(s8_ot));
  mul_booth_pipe #(.W(12), .TW(8)) dut12 (
    .clk(clk), .rst(rst), .in_valid(s12_v), .in_ready(s12_rdy), .in_a(s12_a), .in_b(s12_b),
    .in_signed(s12_s), .in_tag(s12_t), .out_valid(s12_ov), .out_ready(1'b1),
    .out_product(s12_p), .out_tag(s12_ot));
  mul_booth_pipe #(.W(32), .TW(16)) dut32 (
    .clk(clk), .rst(rst), .in_valid(s32_v), .in_ready(s32_rdy), .in_a(s32_a), .in_b(s32_b),
    .in_signed(s32_s), .in_tag(s32_t), .out_valid(s32_ov), .out_ready(1'b1),
    .out_product(s32_p), .out_tag(s32_ot));

  // Reference: interpret operands as integers of width w, multiply, keep 2w bits.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, b, input int w, input logic s);
    logic [63:0] ma, mb;
    longint sa, sb, pr;
    ma = {32'd0, a} & ((64'd1 << w) - 64'd1);
    mb = {32'd0, b} & ((64'd1 << w) - 64'd1);
    sa = longint'(ma);
    sb = longint'(mb);
    if (s && ma[w-1]) sa = sa - (longint'(1) << w);
    if (s && mb[w-1]) sb = sb - (longint'(1) << w);
    pr = sa * sb;
    return 64'(pr) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  function automatic logic [31:0] corner(input int k, input int w);
    logic [31:0] m;
    m = (32'd1 << w) - 32'd1;
    case (k)
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'd1 << (w - 1);
      3:       return (32'd1 << (w - 1)) - 32'd1;
      4:       return m;
      default: return $urandom & m;
    endcase
  endfunction

  // One cycle: drive at negedge, report the transfers that happen at the following posedge.
  task automatic tick(input logic r, v, input logic [15:0] a, b, input logic s,
                      input logic [3:0] t, input logic ordy,
                      output logic ofire, output logic [31:0] oprod, output logic [3:0] otag,
                      output logic ifire);
    exp_t e;
    logic [63:0] m;
    @(negedge clk);
    rst = r; in_valid = v; in_a = a; in_b = b; in_signed = s; in_tag = t; out_ready = ordy;
    #1;
    ofire = (out_valid === 1'b1) && out_ready;
    oprod = out_product;
    otag  = out_tag;
    ifire = in_valid && (in_ready === 1'b1) && !rst;
    if (ifire) begin
      m = ref_mul({16'h0, a}, {16'h0, b}, 16, s);
      e.p = m[31:0];
      e.t = t;
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    logic of, ifr;
    logic [31:0] p;
    logic [3:0] tg;
    int outs = 0;
    exp_q.delete();
    tick(1'b1, 1'b1, 16'h1234, 16'h5678, 1'b0, 4'h5, 1'b1, of, p, tg, ifr);
    tick(1'b1, 1'b1, 16'h1234, 16'h5678, 1'b0, 4'h5, 1'b1, of, p, tg, ifr);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_tests++; if (out_product !== 32'h0) begin n_fail++; $display("FAIL reset_product got=%h want=0", out_product); end
    n_tests++; if (out_tag !== 4'h0) begin n_fail++; $display("FAIL reset_tag got=%h want=0", out_tag); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    for (int c = 0; c < 6; c++) begin
      tick(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 4'h0, 1'b1, of, p, tg, ifr);
      if (out_valid !== 1'b0) outs++;
    end
    n_tests++; if (outs != 0) begin n_fail++; $display("FAIL reset_no_accept got=%0d outputs want=0", outs); end
    exp_q.delete();
  endtask

  task automatic test_signed_corners();
    logic [15:0] av [3] = '{16'h8000, 16'hFFFF, 16'h7FFF};
    logic [15:0] bv [3] = '{16'h8000, 16'hFFFF, 16'h8000};
    logic [31:0] want [3] = '{32'h40000000, 32'h00000001, 32'hC0008000};
    logic of, ifr;
    logic [31:0] p;
    logic [3:0] tg;
    int got = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 3) tick(1'b0, 1'b1, av[c], bv[c], 1'b1, 4'(c + 1), 1'b1, of, p, tg, ifr);
      else       tick(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 4'h0, 1'b1, of, p, tg, ifr);
      if (of) begin
        n_tests++;
        if (got >= 3) begin n_fail++; $display("FAIL signed_extra got=%h want=none", p); end
        else if (p !== want[got] || tg !== 4'(got + 1)) begin
          n_fail++;
          $display("FAIL signed_corner[%0d] got=%h/%h want=%h/%h", got, p, tg, want[got], 4'(got + 1));
        end
        got++;
      end
    end
    n_tests++; if (got != 3) begin n_fail++; $display("FAIL signed_count got=%0d want=3", got); end
    exp_q.delete();
  endtask

  task automatic test_unsigned_mixed();
    logic [15:0] av [6] = '{16'hFFFF, 16'h8000, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h8000};
    logic [15:0] bv [6] = '{16'hFFFF, 16'h0002, 16'hFFFF, 16'hFFFF, 16'h0002, 16'h0002};
    logic        sv [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] want [6] = '{32'hFFFE0001, 32'h00010000, 32'h00000001,
                              32'hFFFE0001, 32'hFFFF0000, 32'h00010000};
    logic of, ifr;
    logic [31:0] p;
    logic [3:0] tg;
    int got = 0;
    for (int c = 0; c < 14; c++) begin
      if (c < 6) tick(1'b0, 1'b1, av[c], bv[c], sv[c], 4'(c + 1), 1'b1, of, p, tg, ifr);
      else       tick(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 4'h0, 1'b1, of, p, tg, ifr);
      if (of) begin
        n_tests++;
        if (got >= 6) begin n_fail++; $display("FAIL mixed_extra got=%h want=none", p); end
        else if (p !== want[got] || tg !== 4'(got + 1)) begin
          n_fail++;
          $display("FAIL mixed_mode[%0d] got=%h/%h want=%h/%h", got, p, tg, want[got], 4'(got + 1));
        end
        got++;
      end
    end
    n_tests++; if (got != 6) begin n_fail++; $display("FAIL mixed_count got=%0d want=6", got); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic of, ifr;
    logic [31:0] p;
    logic [3:0] tg;
    exp_t e;
    int sent = 0, got = 0, first_acc = -1, first_out = -1, last_out = -1, gaps = 0;
    for (int c = 0; c < 140 && got < 100; c++) begin
      tick(1'b0, sent < 100, 16'($urandom), 16'($urandom), 1'($urandom), 4'(sent), 1'b1,
           of, p, tg, ifr);
      if (ifr) begin
        if (first_acc < 0) first_acc = c;
        sent++;
      end
      if (of) begin
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL stream_extra got=%h want=none", p); end
        else begin
          e = exp_q.pop_front();
          if (p !== e.p || tg !== e.t) begin
            n_fail++; $display("FAIL stream[%0d] got=%h/%h want=%h/%h", got, p, tg, e.p, e.t);
          end
        end
        if (first_out < 0) first_out = c;
        else if (c != last_out + 1) gaps++;
        last_out = c;
        got++;
      end
    end
    n_tests++; if (got != 100) begin n_fail++; $display("FAIL stream_count got=%0d want=100", got); end
    // Accepted at the edge of tick a, visible after edge a+3, i.e. in tick a+4.
    n_tests++;
    if (first_out != first_acc + 4) begin
      n_fail++; $display("FAIL stream_latency got=%0d want=%0d", first_out - first_acc - 1, 3);
    end
    n_tests++; if (gaps != 0) begin n_fail++; $display("FAIL stream_gaps got=%0d want=0", gaps); end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic of, ifr, ordy;
    logic [31:0] p, held_p;
    logic [3:0] tg, held_t;
    logic [15:0] pa, pb;
    logic ps;
    exp_t e;
    int sent = 0, got = 0, gaps = 0;
    held_p = '0; held_t = '0;
    pa = 16'($urandom); pb = 16'($urandom); ps = 1'($urandom);
    for (int c = 0; c < 60 && got < 20; c++) begin
      ordy = !(c >= 6 && c < 11);
      tick(1'b0, sent < 20, pa, pb, ps, 4'(sent), ordy, of, p, tg, ifr);
      if (ifr) begin
        sent++;
        pa = 16'($urandom); pb = 16'($urandom); ps = 1'($urandom);
      end
      if (!ordy) begin
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          n_fail++; $display("FAIL stall_ready c=%0d got in_ready=%b out_valid=%b want 0/1", c, in_ready, out_valid);
        end
        if (c == 6) begin held_p = out_product; held_t = out_tag; end
        else begin
          n_tests++;
          if (out_product !== held_p || out_tag !== held_t) begin
            n_fail++; $display("FAIL stall_stable c=%0d got=%h/%h want=%h/%h", c, out_product, out_tag, held_p, held_t);
          end
        end
      end
      if (of) begin
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_extra got=%h want=none", p); end
        else begin
          e = exp_q.pop_front();
          if (p !== e.p || tg !== e.t) begin
            n_fail++; $display("FAIL bp_order[%0d] got=%h/%h want=%h/%h", got, p, tg, e.p, e.t);
          end
        end
        got++;
      end
      if (c >= 11 && !of && exp_q.size() > (ifr ? 1 : 0)) gaps++;
    end
    n_tests++; if (got != 20) begin n_fail++; $display("FAIL bp_count got=%0d want=20", got); end
    n_tests++; if (gaps != 0) begin n_fail++; $display("FAIL bp_gaps got=%0d want=0", gaps); end
    exp_q.delete();
  endtask

  task automatic test_reset_midstream();
    logic of, ifr;
    logic [31:0] p;
    logic [3:0] tg;
    exp_t e;
    int got = 0;
    for (int c = 0; c < 14; c++) begin
      if (c < 3)
        tick(1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'b1, 4'(c + 1), 1'b1, of, p, tg, ifr);
      else if (c == 3) begin
        tick(1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'b0, 4'hF, 1'b1, of, p, tg, ifr);
        exp_q.delete();
      end else if (c < 6)
        tick(1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'b0, 4'(c + 6), 1'b1, of, p, tg, ifr);
      else
        tick(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 4'h0, 1'b1, of, p, tg, ifr);
      if (c == 4) begin
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got=%b want=0", out_valid); end
      end
      if (of) begin
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rst_mid_stale got=%h/%h want=none", p, tg); end
        else begin
          e = exp_q.pop_front();
          if (p !== e.p || tg !== e.t) begin
            n_fail++; $display("FAIL rst_mid[%0d] got=%h/%h want=%h/%h", got, p, tg, e.p, e.t);
          end
        end
        got++;
      end
    end
    n_tests++; if (got != 2) begin n_fail++; $display("FAIL rst_mid_count got=%0d want=2", got); end
    exp_q.delete();
  endtask

  task automatic test_param_sweep();
    logic [63:0] q8[$], q12[$], q32[$];
    logic [63:0] e;
    logic [31:0] ta, tb;
    logic s;
    int ka, kb;
    int total = 96;
    for (int c = 0; c < total + 4; c++) begin
      @(negedge clk);
      if (c < total) begin
        if (c < 72) begin ka = c / 12; kb = (c / 2) % 6; s = c[0]; end
        else begin ka = 5; kb = 5; s = 1'($urandom); end
        ta = corner(ka, 8);  tb = corner(kb, 8);
        s8_a = ta[7:0];  s8_b = tb[7:0];  s8_s = s;  s8_t = 1'(c);  s8_v = 1'b1;
        q8.push_back(ref_mul(ta, tb, 8, s));
        ta = corner(ka, 12); tb = corner(kb, 12);
        s12_a = ta[11:0]; s12_b = tb[11:0]; s12_s = s; s12_t = 8'(c); s12_v = 1'b1;
        q12.push_back(ref_mul(ta, tb, 12, s));
        ta = corner(ka, 32); tb = corner(kb, 32);
        s32_a = ta; s32_b = tb; s32_s = s; s32_t = 16'(c); s32_v = 1'b1;
        q32.push_back(ref_mul(ta, tb, 32, s));
      end else begin
        s8_v = 1'b0; s12_v = 1'b0; s32_v = 1'b0;
      end
      #1;
      if (c >= 4) begin
        e = q8.pop_front();
        n_tests++;
        if (s8_ov !== 1'b1 || s8_p !== e[15:0]) begin
          n_fail++; $display("FAIL sweep_w8[%0d] got=%b/%h want=1/%h", c - 4, s8_ov, s8_p, e[15:0]);
        end
        e = q12.pop_front();
        n_tests++;
        if (s12_ov !== 1'b1 || s12_p !== e[23:0]) begin
          n_fail++; $display("FAIL sweep_w12[%0d] got=%b/%h want=1/%h", c - 4, s12_ov, s12_p, e[23:0]);
        end
        e = q32.pop_front();
        n_tests++;
        if (s32_ov !== 1'b1 || s32_p !== e) begin
          n_fail++; $display("FAIL sweep_w32[%0d] got=%b/%h want=1/%h", c - 4, s32_ov, s32_p, e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_signed_corners();
    test_unsigned_mixed();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_param_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
